// File: rtl/interrupt_queue.sv
// interrupt_queue
//   Turns rising edges on game-IO interrupt request lines into 32-bit
//   instruction words. The words are buffered in arrival order and the head
//   word is presented to the processor. Each source has a sticky pending bit.
//   When several sources are pending, the lowest index is granted first. At
//   most one word is enqueued per cycle. An all-zero word means "no interrupt".
//
// Ports
//   clock                  system clock, all state updates on posedge
//   reset                  synchronous, active-high
//   irq_req                level request lines, a rising edge is one event
//   irq_instr              per-source instruction word, src i at [32*i +: 32]
//   int_enable             0 masks the output to zero and ignores int_ack
//   int_ack                processor consumed the head word (1-cycle pulse)
//   interrupt_instruction  head word, or zero when empty or masked
//   int_pending            queue holds at least one word
//   queue_count            words currently stored, 0..DEPTH
//   drop_count             events lost, saturating at 255
module interrupt_queue #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 8,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   irq_req,
  input  logic [NUM_SRC*32-1:0] irq_instr,
  input  logic                 int_enable,
  input  logic                 int_ack,
  output logic [31:0]          interrupt_instruction,
  output logic                 int_pending,
  output logic [CW-1:0]        queue_count,
  output logic [7:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(NUM_SRC + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [NUM_SRC-1:0] prev_req;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] drop_hit;
  logic [NUM_SRC-1:0] pending_next;
  logic               push;
  logic               pop;
  logic [31:0]        push_word;
  logic [DW-1:0]      drop_inc;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_next;
  logic [CW-1:0]      count_next;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [31:0]        mem [DEPTH];

  always_comb begin
    rise = irq_req & ~prev_req;

    // Eligibility uses the pre-edge count: a full queue never accepts a
    // push, even on an edge where it is also popped.
    push = (pending != '0) && (queue_count < FULL_COUNT);

    // x & (~x + 1) isolates the lowest set bit, which is the highest-priority source.
    grant = '0;
    if (push) begin
      grant = pending & (~pending + NUM_SRC'(1));
    end

    push_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        push_word = irq_instr[32*i +: 32];
      end
    end

    pop = int_ack && int_enable && (queue_count != '0);

    // A new edge on a source that is already pending is lost, unless that
    // source's older event leaves the pending bit on this very edge.
    drop_hit = rise & pending & ~grant;
    drop_inc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_inc = drop_inc + DW'(drop_hit[i]);
    end
    drop_sum  = {1'b0, drop_count} + 9'(drop_inc);
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    pending_next = (pending & ~grant) | rise;

    count_next = queue_count;
    case ({push, pop})
      2'b10:   count_next = queue_count + CW'(1);
      2'b01:   count_next = queue_count - CW'(1);
      default: count_next = queue_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_req    <= '0;
      pending     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      queue_count <= '0;
      drop_count  <= '0;
    end else begin
      prev_req    <= irq_req;
      pending     <= pending_next;
      drop_count  <= drop_next;
      queue_count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage is not cleared by reset; occupancy is tracked by queue_count.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  assign interrupt_instruction = (int_enable && (queue_count != '0)) ? mem[rd_ptr] : 32'd0;
  assign int_pending           = (queue_count != '0);

endmodule

// File: tb/tb_interrupt_queue.sv
module tb_interrupt_queue;

  localparam int NUM_SRC = 4;
  localparam int DEPTH   = 8;
  localparam int CW      = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [NUM_SRC-1:0]      irq_req;
  logic [NUM_SRC*32-1:0]   irq_instr;
  logic                    int_enable;
  logic                    int_ack;
  logic [31:0]             interrupt_instruction;
  logic                    int_pending;
  logic [CW-1:0]           queue_count;
  logic [7:0]              drop_count;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of words, sticky pending flags, last request levels.
  logic [31:0]        m_q[$];
  logic [NUM_SRC-1:0] m_pend;
  logic [NUM_SRC-1:0] m_prev;
  int                 m_drop;

  interrupt_queue #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .irq_req               (irq_req),
    .irq_instr             (irq_instr),
    .int_enable            (int_enable),
    .int_ack               (int_ack),
    .interrupt_instruction (interrupt_instruction),
    .int_pending           (int_pending),
    .queue_count           (queue_count),
    .drop_count            (drop_count)
  );

  always #5 clock = ~clock;

  task automatic model_edge();
    int g;
    bit r;
    bit do_pop;
    logic [NUM_SRC-1:0] np;
    if (reset) begin
      m_q.delete();
      m_pend = '0;
      m_prev = '0;
      m_drop = 0;
      return;
    end
    do_pop = int_ack && int_enable && (m_q.size() != 0);
    g = -1;
    if (m_pend != 0 && m_q.size() < DEPTH) begin
      for (int i = 0; i < NUM_SRC && g < 0; i++)
        if (m_pend[i]) g = i;
    end
    np = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      r = irq_req[i] && !m_prev[i];
      if (r && m_pend[i] && i != g && m_drop < 255) m_drop++;
      np[i] = (m_pend[i] && i != g) || r;
    end
    if (do_pop) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back(irq_instr[32*g +: 32]);
    m_pend = np;
    m_prev = irq_req;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_word(input int src, input logic [31:0] w);
    irq_instr[32*src +: 32] = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_src0(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      set_word(0, base + k);
      irq_req[0] = 1'b1;
      tick();
      irq_req[0] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    irq_req = '0; irq_instr = '0; int_enable = 1'b1; int_ack = 1'b0;
    do_reset();
    total++; if (interrupt_instruction !== 32'd0) $display("FAIL reset_out: got %h want 0", interrupt_instruction); else passed++;
    total++; if (int_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", int_pending); else passed++;
    total++; if (queue_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", queue_count); else passed++;
    total++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    set_word(2, 32'h1234_5678);
    irq_req = 4'b0100;
    tick();
    total++; if (queue_count !== 4'd0) $display("FAIL single_lat_count: got %0d want 0", queue_count); else passed++;
    tick();
    total++; if (interrupt_instruction !== 32'h1234_5678) $display("FAIL single_out: got %h want 12345678", interrupt_instruction); else passed++;
    total++; if (queue_count !== 4'd1) $display("FAIL single_count: got %0d want 1", queue_count); else passed++;
    irq_req = '0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++; if (interrupt_instruction !== 32'd0) $display("FAIL single_ack_out: got %h want 0", interrupt_instruction); else passed++;
    total++; if (queue_count !== 4'd0) $display("FAIL single_ack_count: got %0d want 0", queue_count); else passed++;
    total++; if (int_pending !== 1'b0) $display("FAIL single_ack_pending: got %b want 0", int_pending); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    set_word(0, 32'hAAAA_0000);
    set_word(3, 32'h3333_0003);
    irq_req = 4'b1001;
    tick();
    tick();
    total++; if (interrupt_instruction !== 32'hAAAA_0000) $display("FAIL prio_first: got %h want aaaa0000", interrupt_instruction); else passed++;
    total++; if (queue_count !== 4'd1) $display("FAIL prio_count1: got %0d want 1", queue_count); else passed++;
    tick();
    total++; if (queue_count !== 4'd2) $display("FAIL prio_count2: got %0d want 2", queue_count); else passed++;
    irq_req = '0;
    int_ack = 1'b1;
    tick();
    total++; if (interrupt_instruction !== 32'h3333_0003) $display("FAIL prio_second: got %h want 33330003", interrupt_instruction); else passed++;
    tick();
    int_ack = 1'b0;
    total++; if (interrupt_instruction !== 32'd0) $display("FAIL prio_empty: got %h want 0", interrupt_instruction); else passed++;
  endtask

  task automatic test_full();
    do_reset();
    fill_src0(9, 32'hA000_0000);
    total++; if (queue_count !== 4'd8) $display("FAIL full_count: got %0d want 8", queue_count); else passed++;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++; if (queue_count !== 4'd7) $display("FAIL full_after_ack: got %0d want 7", queue_count); else passed++;
    total++; if (interrupt_instruction !== 32'hA000_0001) $display("FAIL full_head: got %h want a0000001", interrupt_instruction); else passed++;
    tick();
    total++; if (queue_count !== 4'd8) $display("FAIL full_refill: got %0d want 8", queue_count); else passed++;
    total++; if (drop_count !== 8'd0) $display("FAIL full_drop: got %0d want 0", drop_count); else passed++;
    for (int k = 1; k <= 8; k++) begin
      total++; if (interrupt_instruction !== 32'hA000_0000 + k) $display("FAIL full_order%0d: got %h want %h", k, interrupt_instruction, 32'hA000_0000 + k); else passed++;
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
    end
    total++; if (queue_count !== 4'd0) $display("FAIL full_drained: got %0d want 0", queue_count); else passed++;
  endtask

  task automatic test_drop();
    do_reset();
    fill_src0(8, 32'hB000_0000);
    set_word(1, 32'h1111_1111);
    irq_req[1] = 1'b1; tick();
    irq_req[1] = 1'b0; tick();
    irq_req[1] = 1'b1; tick();
    total++; if (drop_count !== 8'd1) $display("FAIL drop_one: got %0d want 1", drop_count); else passed++;
    for (int n = 2; n <= 300; n++) begin
      irq_req[1] = 1'b0; tick();
      irq_req[1] = 1'b1; tick();
      if (n == 254) begin
        total++; if (drop_count !== 8'd254) $display("FAIL drop_254: got %0d want 254", drop_count); else passed++;
      end
    end
    total++; if (drop_count !== 8'd255) $display("FAIL drop_sat: got %0d want 255", drop_count); else passed++;
    total++; if (queue_count !== 4'd8) $display("FAIL drop_count_held: got %0d want 8", queue_count); else passed++;
  endtask

  task automatic test_reset_mid();
    // Continues from the full queue with src1 pending and drop_count saturated.
    irq_req = '0;
    int_ack = 1'b1;
    repeat (4) tick();
    int_ack = 1'b0;
    set_word(2, 32'h2222_2222);
    irq_req = 4'b0110;
    tick();
    total++; if (queue_count !== 4'd5) $display("FAIL rmid_pre_count: got %0d want 5", queue_count); else passed++;
    irq_req = 4'b0100;
    do_reset();
    total++; if (queue_count !== 4'd0) $display("FAIL rmid_count: got %0d want 0", queue_count); else passed++;
    total++; if (interrupt_instruction !== 32'd0) $display("FAIL rmid_out: got %h want 0", interrupt_instruction); else passed++;
    total++; if (drop_count !== 8'd0) $display("FAIL rmid_drop: got %0d want 0", drop_count); else passed++;
    repeat (5) tick();
    total++; if (queue_count !== 4'd1) $display("FAIL rmid_one_event: got %0d want 1", queue_count); else passed++;
    total++; if (interrupt_instruction !== 32'h2222_2222) $display("FAIL rmid_word: got %h want 22222222", interrupt_instruction); else passed++;
    irq_req = '0;
  endtask

  task automatic test_mask();
    do_reset();
    set_word(0, 32'hC0C0_0000);
    set_word(3, 32'hC3C3_0003);
    irq_req = 4'b1001;
    repeat (3) tick();
    irq_req = '0;
    int_enable = 1'b0;
    #1;
    total++; if (interrupt_instruction !== 32'd0) $display("FAIL mask_out: got %h want 0", interrupt_instruction); else passed++;
    int_ack = 1'b1;
    repeat (3) tick();
    int_ack = 1'b0;
    total++; if (queue_count !== 4'd2) $display("FAIL mask_count: got %0d want 2", queue_count); else passed++;
    int_enable = 1'b1;
    #1;
    total++; if (interrupt_instruction !== 32'hC0C0_0000) $display("FAIL mask_unmask: got %h want c0c00000", interrupt_instruction); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_word(0, 32'hD000_0000);
    set_word(1, 32'hD111_1111);
    irq_req = 4'b0001;
    repeat (2) tick();
    irq_req = 4'b0010;
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_req = '0;
    total++; if (queue_count !== 4'd1) $display("FAIL b2b_count: got %0d want 1", queue_count); else passed++;
    total++; if (interrupt_instruction !== 32'hD111_1111) $display("FAIL b2b_out: got %h want d1111111", interrupt_instruction); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp_out;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_SRC; i++)
        if ($urandom_range(0, 9) < 3) irq_req[i] = ~irq_req[i];
      irq_instr  = {$urandom, $urandom, $urandom, $urandom};
      int_enable = ($urandom_range(0, 99) < 85);
      int_ack    = ($urandom_range(0, 99) < 35);
      reset      = ($urandom_range(0, 499) == 0);
      tick();
      reset = 1'b0;
      exp_out = (int_enable && m_q.size() != 0) ? m_q[0] : 32'd0;
      total++; if (interrupt_instruction !== exp_out) $display("FAIL rnd_out c%0d: got %h want %h", c, interrupt_instruction, exp_out); else passed++;
      total++; if (queue_count !== CW'(m_q.size())) $display("FAIL rnd_count c%0d: got %0d want %0d", c, queue_count, m_q.size()); else passed++;
      total++; if (int_pending !== (m_q.size() != 0)) $display("FAIL rnd_pending c%0d: got %b want %b", c, int_pending, m_q.size() != 0); else passed++;
      total++; if (drop_count !== 8'(m_drop)) $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_count, m_drop); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    irq_req = '0;
    irq_instr = '0;
    int_enable = 1'b1;
    int_ack = 1'b0;
    m_pend = '0;
    m_prev = '0;
    m_drop = 0;
    test_reset();
    test_single();
    test_priority();
    test_full();
    test_drop();
    test_reset_mid();
    test_mask();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
